// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with prescaler, load, wrap/saturate, terminal count and compare.
// Optional wrap-event counter enabled by defining MOD_COUNTER_WRAPCNT_EN.
module mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH-1,
    parameter int unsigned PRESCALE = 1
`ifdef MOD_COUNTER_WRAPCNT_EN
    , parameter int unsigned WRAP_CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             cmp_hit
`ifdef MOD_COUNTER_WRAPCNT_EN
    , output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             step;
    logic             at_bound;

    if (PRESCALE > 1) begin : g_pre
        localparam int unsigned PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] p_q, p_d;

        // Load restarts the prescale period so the next step is a full period away.
        always_comb begin
            p_d = p_q;
            if (load) begin
                p_d = '0;
            end else if (en) begin
                p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
            end
        end

        assign step = en && (p_q == P_LAST);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                p_q <= '0;
            end else begin
                p_q <= p_d;
            end
        end
    end else begin : g_nopre
        assign step = en;
    end

    assign at_bound = up_dn ? (out_q == MAX_V) : (out_q == '0);

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        if (load) begin
            out_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step) begin
            tc_d = at_bound;
            if (at_bound) begin
                out_d = sat_mode ? out_q : (up_dn ? '0 : MAX_V);
            end else begin
                out_d = up_dn ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
        end
    end

    assign out     = out_q;
    assign tc      = tc_q;
    assign cmp_hit = (out_q == cmp_val);

`ifdef MOD_COUNTER_WRAPCNT_EN
    logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;

    // Only true wraps count; saturated boundary steps also raise tc but are excluded.
    always_comb begin
        wrap_d = wrap_q;
        if (tc_d && !sat_mode && (wrap_q != '1)) begin
            wrap_d = wrap_q + WRAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: WIDTH=4, MAX_VAL=9 with PRESCALE=1 (dut_a) and PRESCALE=3 (dut_b).
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rstn;

    logic       a_en, a_up, a_load, a_sat;
    logic [3:0] a_lv, a_cmp;
    logic [3:0] a_out;
    logic       a_tc, a_hit;

    logic       b_en, b_load;
    logic [3:0] b_lv;
    logic [3:0] b_out;
    logic       b_tc, b_hit;

`ifdef MOD_COUNTER_WRAPCNT_EN
    logic [7:0] a_wrap, b_wrap;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_a (
        .clk(clk), .rstn(rstn), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .sat_mode(a_sat), .cmp_val(a_cmp),
        .out(a_out), .tc(a_tc), .cmp_hit(a_hit)
`ifdef MOD_COUNTER_WRAPCNT_EN
        , .wrap_cnt(a_wrap)
`endif
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
        .clk(clk), .rstn(rstn), .en(b_en), .up_dn(1'b1), .load(b_load),
        .load_val(b_lv), .sat_mode(1'b0), .cmp_val(4'd0),
        .out(b_out), .tc(b_tc), .cmp_hit(b_hit)
`ifdef MOD_COUNTER_WRAPCNT_EN
        , .wrap_cnt(b_wrap)
`endif
    );

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic       sat;
        logic [3:0] cmp;
        logic [3:0] exp_out;
        logic       exp_tc;
        logic       exp_hit;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic up, logic load, logic [3:0] lv, logic sat,
                                logic [3:0] cmp, logic [3:0] eo, logic et, logic eh);
        vec_t v;
        v.en = en; v.up = up; v.load = load; v.lv = lv; v.sat = sat; v.cmp = cmp;
        v.exp_out = eo; v.exp_tc = et; v.exp_hit = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_cycle(input logic en, input logic load, input logic [3:0] lv,
                           input logic [3:0] eo, input string name);
        b_en = en; b_load = load; b_lv = lv;
        tick();
        chk(name, {28'd0, b_out}, {28'd0, eo});
    endtask

    initial begin
        rstn = 1'b0;
        a_en = 0; a_up = 1; a_load = 0; a_lv = 0; a_sat = 0; a_cmp = 4'd7;
        b_en = 0; b_load = 0; b_lv = 0;

        // counting up with wrap, compare at 7
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(1, 1, 0, 0, 0, 7, 4'(i), 0, (i == 7)));
        vecs.push_back(mk(1, 1, 0, 0, 0, 7, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 7, 1, 0, 0));
        // load 0 then count down with wrap
        vecs.push_back(mk(1, 0, 1, 0, 0, 7, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 9, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 8, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 7, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 6, 0, 0));
        // saturate at 0: tc every step
        vecs.push_back(mk(1, 0, 1, 0, 1, 7, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 7, 0, 1, 0));
        // clamped load, saturate at MAX_VAL, hold with en=0
        vecs.push_back(mk(1, 1, 1, 12, 1, 7, 9, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 7, 9, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 7, 9, 0, 0));
        // load wins over step on the same edge
        vecs.push_back(mk(1, 1, 1, 5, 0, 7, 5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 4, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5, 5, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("reset a_out", {28'd0, a_out}, 0);
        chk("reset a_tc", {31'd0, a_tc}, 0);
        chk("reset b_out", {28'd0, b_out}, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            a_en = vecs[i].en; a_up = vecs[i].up; a_load = vecs[i].load;
            a_lv = vecs[i].lv; a_sat = vecs[i].sat; a_cmp = vecs[i].cmp;
            tick();
            chk($sformatf("vec%0d out", i), {28'd0, a_out}, {28'd0, vecs[i].exp_out});
            chk($sformatf("vec%0d tc", i), {31'd0, a_tc}, {31'd0, vecs[i].exp_tc});
            chk($sformatf("vec%0d cmp_hit", i), {31'd0, a_hit}, {31'd0, vecs[i].exp_hit});
        end
`ifdef MOD_COUNTER_WRAPCNT_EN
        chk("wrap_cnt true wraps", {24'd0, a_wrap}, 2);
`endif

        // compare follows cmp_val without a clock edge (out is 5)
        a_en = 0; a_load = 0;
        a_cmp = 4'd0;
        #1 chk("cmp_hit cmp change low", {31'd0, a_hit}, 0);
        a_cmp = 4'd5;
        #1 chk("cmp_hit cmp change high", {31'd0, a_hit}, 1);
        tick();

        // prescaler: en 1,1,1,0,0,1,1,1
        b_cycle(1, 0, 0, 0, "pre e1");
        b_cycle(1, 0, 0, 0, "pre e2");
        b_cycle(1, 0, 0, 1, "pre e3");
        b_cycle(0, 0, 0, 1, "pre e4");
        b_cycle(0, 0, 0, 1, "pre e5");
        b_cycle(1, 0, 0, 1, "pre e6");
        b_cycle(1, 0, 0, 1, "pre e7");
        b_cycle(1, 0, 0, 2, "pre e8");
        // load mid-period restarts the prescaler
        b_cycle(1, 0, 0, 2, "pre mid");
        b_cycle(1, 1, 5, 5, "pre load");
        b_cycle(1, 0, 0, 5, "pre after load 1");
        b_cycle(1, 0, 0, 5, "pre after load 2");
        b_cycle(1, 0, 0, 6, "pre after load 3");
        b_cycle(1, 0, 0, 6, "pre before reset");
        b_en = 0;

        // async reset between edges while tc is high
        a_en = 1; a_up = 1; a_sat = 1; a_load = 1; a_lv = 9;
        tick();
        a_load = 0;
        tick();
        chk("pre-reset a_out", {28'd0, a_out}, 9);
        chk("pre-reset a_tc", {31'd0, a_tc}, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async reset a_out", {28'd0, a_out}, 0);
        chk("async reset a_tc", {31'd0, a_tc}, 0);
        chk("async reset b_out", {28'd0, b_out}, 0);
`ifdef MOD_COUNTER_WRAPCNT_EN
        chk("async reset wrap_cnt", {24'd0, a_wrap}, 0);
`endif
        tick();
        chk("held reset a_out", {28'd0, a_out}, 0);
        @(negedge clk);
        rstn = 1'b1;
        a_sat = 0;
        tick();
        chk("restart a_out", {28'd0, a_out}, 1);
        a_en = 0;
        b_cycle(1, 0, 0, 0, "restart p 1");
        b_cycle(1, 0, 0, 0, "restart p 2");
        b_cycle(1, 0, 0, 1, "restart p 3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
